// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl handshake performance monitor: transaction/latency/busy/stall
// counters with saturation flags and a registered one-cycle readout port.
module ap_ctrl_perf_monitor #(
  parameter int              N_CH    = 16,
  parameter int              CNT_W   = 32,
  parameter logic [N_CH-1:0] HS_MASK = {N_CH{1'b1}}
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [N_CH-1:0]  ch_ap_start,
  input  logic [N_CH-1:0]  ch_ap_ready,
  input  logic [N_CH-1:0]  ch_ap_done,
  input  logic [N_CH-1:0]  ch_ap_continue,
  input  logic             finish,
  input  logic             clear,
  input  logic [4:0]       rd_ch,
  input  logic [2:0]       rd_sel,
  input  logic             rd_req,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [N_CH-1:0]  ovf,
  output logic             all_idle
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Reset asserts at once but releases only after two ap_clk edges.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  // Sized to the full 5-bit rd_ch range so out-of-range channels read as zero.
  logic [31:0][CNT_W-1:0] txn_v, busy_v, stall_v, last_v, max_v, ready_v;
  logic [N_CH-1:0]        idle_v;

  for (genvar i = 0; i < 32; i++) begin : g_ch
    if (i < N_CH) begin : g_on
      ch_state_t        state, state_nxt;
      logic [CNT_W-1:0] lat, txn, busy, stall, last_lat, max_lat, ready_cnt;
      logic [CNT_W-1:0] cpl_lat;
      logic             ovf_q;
      logic             busy_evt, stall_evt, lat_load, lat_evt, cpl, lat_wrap, wrap;

      always_comb begin
        state_nxt = state;
        busy_evt  = 1'b0;
        stall_evt = 1'b0;
        lat_load  = 1'b0;
        lat_evt   = 1'b0;
        cpl       = 1'b0;
        lat_wrap  = 1'b0;
        cpl_lat   = CNT_ONE;
        if (HS_MASK[i]) begin
          unique case (state)
            IDLE: begin
              if (ch_ap_start[i]) begin
                busy_evt = 1'b1;
                if (ch_ap_done[i]) begin
                  cpl       = 1'b1;
                  state_nxt = ch_ap_continue[i] ? IDLE : DONE_WAIT;
                end else begin
                  lat_load  = 1'b1;
                  state_nxt = BUSY;
                end
              end
            end
            BUSY: begin
              busy_evt = 1'b1;
              lat_wrap = (lat == CNT_MAX);
              if (ch_ap_done[i]) begin
                cpl       = 1'b1;
                cpl_lat   = sat_inc(lat);
                state_nxt = ch_ap_continue[i] ? IDLE : DONE_WAIT;
              end else begin
                lat_evt = 1'b1;
              end
            end
            DONE_WAIT: begin
              stall_evt = 1'b1;
              if (ch_ap_continue[i]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end

      assign wrap = (busy_evt && (busy == CNT_MAX)) ||
                    (stall_evt && (stall == CNT_MAX)) ||
                    (cpl && (txn == CNT_MAX)) ||
                    lat_wrap ||
                    (ch_ap_ready[i] && (ready_cnt == CNT_MAX));

      always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n)   state <= IDLE;
        else if (clear)   state <= IDLE;
        else if (!finish) state <= state_nxt;
      end

      always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
          lat       <= '0;
          txn       <= '0;
          busy      <= '0;
          stall     <= '0;
          last_lat  <= '0;
          max_lat   <= '0;
          ready_cnt <= '0;
          ovf_q     <= 1'b0;
        end else if (clear) begin
          lat       <= '0;
          txn       <= '0;
          busy      <= '0;
          stall     <= '0;
          last_lat  <= '0;
          max_lat   <= '0;
          ready_cnt <= '0;
          ovf_q     <= 1'b0;
        end else if (!finish) begin
          if (lat_load)     lat <= CNT_ONE;
          else if (lat_evt) lat <= sat_inc(lat);
          if (busy_evt)  busy  <= sat_inc(busy);
          if (stall_evt) stall <= sat_inc(stall);
          if (cpl) begin
            txn      <= sat_inc(txn);
            last_lat <= cpl_lat;
            if (cpl_lat > max_lat) max_lat <= cpl_lat;
          end
          if (ch_ap_ready[i]) ready_cnt <= sat_inc(ready_cnt);
          if (wrap) ovf_q <= 1'b1;
        end
      end

      assign txn_v[i]   = txn;
      assign busy_v[i]  = busy;
      assign stall_v[i] = stall;
      assign last_v[i]  = last_lat;
      assign max_v[i]   = max_lat;
      assign ready_v[i] = ready_cnt;
      assign ovf[i]     = ovf_q;
      assign idle_v[i]  = (state == IDLE);
    end else begin : g_off
      assign txn_v[i]   = '0;
      assign busy_v[i]  = '0;
      assign stall_v[i] = '0;
      assign last_v[i]  = '0;
      assign max_v[i]   = '0;
      assign ready_v[i] = '0;
    end
  end

  assign all_idle = &idle_v;

  logic [CNT_W-1:0] field;

  always_comb begin
    field = '0;
    case (rd_sel)
      3'd0:    field = txn_v[rd_ch];
      3'd1:    field = busy_v[rd_ch];
      3'd2:    field = stall_v[rd_ch];
      3'd3:    field = last_v[rd_ch];
      3'd4:    field = max_v[rd_ch];
      3'd5:    field = ready_v[rd_ch];
      default: field = '0;
    endcase
  end

  // Readout samples pre-edge counter values and is not frozen by finish.
  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= field;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Self-checking bench for ap_ctrl_perf_monitor: directed scenarios plus random
// traffic compared against a timestamp-based behavioural model.
module tb_ap_ctrl_perf_monitor;
  localparam int          N_CH  = 16;
  localparam int          CNT_W = 8;
  localparam logic [15:0] HS    = 16'hFFDF;
  localparam int          CMAX  = 255;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [15:0] ch_ap_start, ch_ap_ready, ch_ap_done, ch_ap_continue;
  logic        finish, clear, rd_req;
  logic [4:0]  rd_ch;
  logic [2:0]  rd_sel;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] ovf;
  logic        all_idle;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: counters as plain ints; latency from a live-cycle timestamp.
  int          m_txn[16], m_busy[16], m_stall[16], m_last[16], m_max[16], m_ready[16];
  int          m_start_t[16];
  bit          m_running[16], m_waiting[16];
  logic [15:0] m_ovf;
  int          live;
  logic [7:0]  last_rd;

  ap_ctrl_perf_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .HS_MASK(HS)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .ch_ap_start(ch_ap_start), .ch_ap_ready(ch_ap_ready),
    .ch_ap_done(ch_ap_done), .ch_ap_continue(ch_ap_continue),
    .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .ovf(ovf), .all_idle(all_idle)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_txn[c] = 0; m_busy[c] = 0; m_stall[c] = 0; m_last[c] = 0;
      m_max[c] = 0; m_ready[c] = 0; m_start_t[c] = 0;
      m_running[c] = 1'b0; m_waiting[c] = 1'b0;
    end
    m_ovf = '0;
  endfunction

  function automatic int sat_add(input int v, input int ch);
    if (v >= CMAX) begin
      m_ovf[ch] = 1'b1;
      return CMAX;
    end
    return v + 1;
  endfunction

  function automatic void model_step();
    int lat;
    if (clear) begin
      model_clear();
    end else if (!finish) begin
      live++;
      for (int c = 0; c < N_CH; c++) begin
        if (ch_ap_ready[c]) m_ready[c] = sat_add(m_ready[c], c);
        if (HS[c]) begin
          if (m_waiting[c]) begin
            m_stall[c] = sat_add(m_stall[c], c);
            if (ch_ap_continue[c]) m_waiting[c] = 1'b0;
          end else if (m_running[c] || ch_ap_start[c]) begin
            if (!m_running[c]) begin
              m_running[c] = 1'b1;
              m_start_t[c] = live;
            end
            m_busy[c] = sat_add(m_busy[c], c);
            lat = live - m_start_t[c] + 1;
            if (lat > CMAX) begin
              m_ovf[c] = 1'b1;
              lat = CMAX;
            end
            if (ch_ap_done[c]) begin
              m_txn[c]     = sat_add(m_txn[c], c);
              m_last[c]    = lat;
              if (lat > m_max[c]) m_max[c] = lat;
              m_running[c] = 1'b0;
              m_waiting[c] = !ch_ap_continue[c];
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [7:0] model_field(input logic [4:0] ch, input logic [2:0] sel);
    int v;
    int c;
    v = 0;
    c = int'(ch);
    if (c < N_CH) begin
      case (sel)
        3'd0:    v = m_txn[c];
        3'd1:    v = m_busy[c];
        3'd2:    v = m_stall[c];
        3'd3:    v = m_last[c];
        3'd4:    v = m_max[c];
        3'd5:    v = m_ready[c];
        default: v = 0;
      endcase
    end
    return 8'(v);
  endfunction

  function automatic logic model_all_idle();
    for (int c = 0; c < N_CH; c++)
      if (HS[c] && (m_running[c] || m_waiting[c])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus();
    logic       req;
    logic [7:0] exp_rd;
    req    = rd_req;
    exp_rd = model_field(rd_ch, rd_sel);
    @(posedge ap_clk);
    model_step();
    #1;
    if (req) last_rd = exp_rd;
    checkOutput("rd_valid", 64'(rd_valid), 64'(req));
    checkOutput("rd_data", 64'(rd_data), 64'(last_rd));
    checkOutput("ovf", 64'(ovf), 64'(m_ovf));
    checkOutput("all_idle", 64'(all_idle), 64'(model_all_idle()));
  endtask

  task automatic idleInputs();
    ch_ap_start    = '0;
    ch_ap_done     = '0;
    ch_ap_ready    = '0;
    ch_ap_continue = '1;
    finish         = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rd_req = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1;
    model_clear();
    last_rd = '0;
    checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
    checkOutput("rst_all_idle", 64'(all_idle), 64'd1);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    repeat (3) applyStimulus();
  endtask

  task automatic readField(input int ch, input int sel, output logic [7:0] val);
    rd_req = 1'b1;
    rd_ch  = 5'(ch);
    rd_sel = 3'(sel);
    applyStimulus();
    rd_req = 1'b0;
    val    = rd_data;
  endtask

  initial begin
    logic [7:0] v;
    ap_rst_n = 1'b1;
    rd_req   = 1'b0;
    rd_ch    = '0;
    rd_sel   = '0;
    live     = 0;
    idleInputs();
    model_clear();
    doReset();

    // Ready-only channel: no transaction accounting, ready still counted.
    ch_ap_start[5] = 1'b1; ch_ap_done[5] = 1'b1; ch_ap_ready[5] = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("ch5_all_idle", 64'(all_idle), 64'd1);
    idleInputs();
    readField(5, 0, v); checkOutput("ch5_txn", 64'(v), 64'd0);
    readField(5, 1, v); checkOutput("ch5_busy", 64'(v), 64'd0);
    readField(5, 5, v); checkOutput("ch5_ready", 64'(v), 64'd3);

    // Ch0: start for one cycle, done five cycles later.
    ch_ap_start[0] = 1'b1; applyStimulus(); ch_ap_start[0] = 1'b0;
    repeat (4) applyStimulus();
    ch_ap_done[0] = 1'b1; applyStimulus(); ch_ap_done[0] = 1'b0;
    readField(0, 0, v); checkOutput("ch0_txn", 64'(v), 64'd1);
    readField(0, 3, v); checkOutput("ch0_last_lat", 64'(v), 64'd6);
    readField(0, 4, v); checkOutput("ch0_max_lat", 64'(v), 64'd6);
    readField(0, 1, v); checkOutput("ch0_busy", 64'(v), 64'd6);
    readField(0, 2, v); checkOutput("ch0_stall", 64'(v), 64'd0);

    // Ch1: three single-cycle transactions.
    ch_ap_start[1] = 1'b1; ch_ap_done[1] = 1'b1;
    repeat (3) applyStimulus();
    idleInputs();
    readField(1, 0, v); checkOutput("ch1_txn", 64'(v), 64'd3);
    readField(1, 3, v); checkOutput("ch1_last_lat", 64'(v), 64'd1);
    readField(1, 1, v); checkOutput("ch1_busy", 64'(v), 64'd3);

    // Ch3: done held off by continue=0 for four cycles.
    ch_ap_start[3] = 1'b1; applyStimulus(); ch_ap_start[3] = 1'b0;
    ch_ap_done[3] = 1'b1; ch_ap_continue[3] = 1'b0; applyStimulus(); ch_ap_done[3] = 1'b0;
    checkOutput("ch3_all_idle_wait", 64'(all_idle), 64'd0);
    repeat (3) applyStimulus();
    checkOutput("ch3_all_idle_still", 64'(all_idle), 64'd0);
    ch_ap_continue[3] = 1'b1; applyStimulus();
    checkOutput("ch3_all_idle_back", 64'(all_idle), 64'd1);
    readField(3, 2, v); checkOutput("ch3_stall", 64'(v), 64'd4);
    readField(3, 0, v); checkOutput("ch3_txn", 64'(v), 64'd1);

    // Ch2: ready saturation then clear.
    ch_ap_ready[2] = 1'b1;
    repeat (300) applyStimulus();
    idleInputs();
    readField(2, 5, v); checkOutput("ch2_ready_sat", 64'(v), 64'd255);
    checkOutput("ch2_ovf_set", 64'(ovf[2]), 64'd1);
    clear = 1'b1; applyStimulus(); clear = 1'b0;
    readField(2, 5, v); checkOutput("ch2_ready_clr", 64'(v), 64'd0);
    checkOutput("ch2_ovf_clr", 64'(ovf[2]), 64'd0);

    // Ch4: ten frozen cycles mid-transaction are excluded from latency.
    ch_ap_start[4] = 1'b1; applyStimulus(); ch_ap_start[4] = 1'b0;
    repeat (2) applyStimulus();
    finish = 1'b1;
    repeat (9) applyStimulus();
    readField(4, 1, v); checkOutput("ch4_busy_frozen", 64'(v), 64'd3);
    finish = 1'b0;
    applyStimulus();
    ch_ap_done[4] = 1'b1; applyStimulus(); ch_ap_done[4] = 1'b0;
    readField(4, 3, v); checkOutput("ch4_last_lat", 64'(v), 64'd5);
    readField(20, 0, v); checkOutput("rd_ch20_data", 64'(v), 64'd0);
    checkOutput("rd_ch20_valid", 64'(rd_valid), 64'd1);

    // Ch6: reset in the middle of BUSY, then a fresh 2-cycle transaction.
    ch_ap_start[6] = 1'b1; applyStimulus(); ch_ap_start[6] = 1'b0;
    repeat (3) applyStimulus();
    doReset();
    ch_ap_start[6] = 1'b1; applyStimulus(); ch_ap_start[6] = 1'b0;
    ch_ap_done[6] = 1'b1; applyStimulus(); ch_ap_done[6] = 1'b0;
    readField(6, 0, v); checkOutput("ch6_txn", 64'(v), 64'd1);
    readField(6, 3, v); checkOutput("ch6_last_lat", 64'(v), 64'd2);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      ch_ap_start    = 16'($urandom);
      ch_ap_done     = 16'($urandom) & 16'($urandom);
      ch_ap_continue = 16'($urandom) | 16'($urandom);
      ch_ap_ready    = 16'($urandom);
      finish         = ($urandom_range(0, 15) == 0);
      clear          = ($urandom_range(0, 299) == 0);
      rd_req         = 1'($urandom_range(0, 1));
      rd_ch          = 5'($urandom_range(0, 19));
      rd_sel         = 3'($urandom_range(0, 7));
      applyStimulus();
    end

    idleInputs();
    rd_req = 1'b0;
    for (int c = 0; c < 18; c++)
      for (int s = 0; s < 8; s++)
        readField(c, s, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
